// File: rtl/byte_serializer_pkg.sv
// Shared definitions for the serializer -> deserializer -> queue chain.
// Holds the serializer FSM state type and the common byte width so every
// block in the chain agrees on the frame size.
package serializer_pkg;

    // Serializer FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RX = 2'd1,
        SHIFT   = 2'd2,
        GAP     = 2'd3
    } ser_state_t;

    // Byte width shared by the serializer, deserializer and queue.
    localparam int SER_DATA_W = 8;

    // Width of the inter-bit gap counter (BIT_GAP range 0..15).
    localparam int SER_GAP_W = 4;

endpackage

// File: rtl/byte_serializer_if.sv
// Bundle of the byte handshake and serial link signals around the serializer.
//   byte_in / byte_valid_in / byte_ready_out : parallel byte handshake
//   status_in                                : deserializer availability
//   data_out / write_out                     : serial bit and its strobe
//   done_out / busy_out                      : frame status
// modport slave  : the serializer itself
// modport master : whoever feeds bytes and observes the serial side
interface byte_serializer_if
    import serializer_pkg::*;
#(
    parameter int DATA_W = SER_DATA_W
) ();

    logic [DATA_W-1:0] byte_in;
    logic              byte_valid_in;
    logic              byte_ready_out;
    logic              status_in;
    logic              data_out;
    logic              write_out;
    logic              done_out;
    logic              busy_out;

    modport slave (
        input  byte_in,
        input  byte_valid_in,
        input  status_in,
        output byte_ready_out,
        output data_out,
        output write_out,
        output done_out,
        output busy_out
    );

    modport master (
        output byte_in,
        output byte_valid_in,
        output status_in,
        input  byte_ready_out,
        input  data_out,
        input  write_out,
        input  done_out,
        input  busy_out
    );

endinterface

// File: rtl/byte_serializer.sv
// Parallel-to-serial stage feeding the deserializer.
// Accepts a byte on the valid/ready handshake, waits for the deserializer to
// report available, then sends the byte one bit per write strobe with an
// optional idle gap between bits. All outputs are registered.
// Ports:
//   clk_100mhz : system clock, rising edge
//   reset      : asynchronous active-low reset
//   bus        : byte_serializer_if.slave (handshake, status, serial outputs)
module byte_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W    = SER_DATA_W,
    parameter int BIT_GAP   = 0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_100mhz,
    input  logic              reset,
    byte_serializer_if.slave  bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [SER_GAP_W-1:0] GAP_LOAD =
        (BIT_GAP > 0) ? SER_GAP_W'(BIT_GAP - 1) : {SER_GAP_W{1'b0}};

    ser_state_t             state_r,   state_s;
    logic [DATA_W-1:0]      shift_r,   shift_s;
    logic [CNT_W-1:0]       bit_cnt_r, bit_cnt_s;
    logic [SER_GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
    logic                   data_r,    data_s;
    logic                   write_r,   write_s;
    logic                   done_r,    done_s;
    logic                   ready_r,   ready_s;
    logic                   busy_r,    busy_s;
    logic                   emit_s;
    logic                   cur_bit_s;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        gap_cnt_s = gap_cnt_r;
        data_s    = data_r;
        write_s   = 1'b0;
        done_s    = 1'b0;
        emit_s    = 1'b0;
        cur_bit_s = MSB_FIRST ? shift_r[DATA_W-1] : shift_r[0];

        case (state_r)
            IDLE: begin
                if (bus.byte_valid_in) begin
                    shift_s   = bus.byte_in;
                    bit_cnt_s = {CNT_W{1'b0}};
                    state_s   = WAIT_RX;
                end else begin
                    state_s   = IDLE;
                end
            end
            WAIT_RX: begin
                if (bus.status_in) begin
                    emit_s  = 1'b1;
                    state_s = SHIFT;
                end else begin
                    state_s = WAIT_RX;
                end
            end
            SHIFT: begin
                // bit_cnt_r is the index of the bit on the line this cycle.
                if (bit_cnt_r == LAST_BIT) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    if (BIT_GAP == 0) begin
                        emit_s  = 1'b1;
                        state_s = SHIFT;
                    end else begin
                        gap_cnt_s = GAP_LOAD;
                        state_s   = GAP;
                    end
                end
            end
            GAP: begin
                // Counter is loaded with BIT_GAP-1 so exactly BIT_GAP idle cycles occur.
                if (gap_cnt_r == {SER_GAP_W{1'b0}}) begin
                    emit_s  = 1'b1;
                    state_s = SHIFT;
                end else begin
                    gap_cnt_s = gap_cnt_r - SER_GAP_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Entering SHIFT puts the next bit on the line with its strobe.
        if (emit_s) begin
            write_s = 1'b1;
            data_s  = cur_bit_s;
            shift_s = MSB_FIRST ? (shift_r << 1) : (shift_r >> 1);
        end else begin
            write_s = 1'b0;
        end

        ready_s = (state_s == IDLE);
        busy_s  = (state_s != IDLE);
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            shift_r   <= {DATA_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            gap_cnt_r <= {SER_GAP_W{1'b0}};
            data_r    <= 1'b0;
            write_r   <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            gap_cnt_r <= gap_cnt_s;
            data_r    <= data_s;
            write_r   <= write_s;
            done_r    <= done_s;
            ready_r   <= ready_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.byte_ready_out = ready_r;
    assign bus.data_out       = data_r;
    assign bus.write_out      = write_r;
    assign bus.done_out       = done_r;
    assign bus.busy_out       = busy_r;

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: one instance with no bit gap and
// one with a two-cycle gap. Stimulus pushes expected bytes into a queue; a
// monitor per instance reassembles serial frames and compares on done_out.
module tb_byte_serializer;
    import serializer_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    byte_serializer_if #(.DATA_W(SER_DATA_W)) bus0 ();
    byte_serializer_if #(.DATA_W(SER_DATA_W)) bus2 ();

    byte_serializer #(.DATA_W(SER_DATA_W), .BIT_GAP(0), .MSB_FIRST(1'b1)) dut0 (
        .clk_100mhz (clk),
        .reset      (reset),
        .bus        (bus0.slave)
    );

    byte_serializer #(.DATA_W(SER_DATA_W), .BIT_GAP(2), .MSB_FIRST(1'b1)) dut2 (
        .clk_100mhz (clk),
        .reset      (reset),
        .bus        (bus2.slave)
    );

    int total = 0;
    int bad   = 0;
    int wr0   = 0;
    logic [7:0] q0[$];
    logic [7:0] q2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard monitor for the no-gap instance.
    initial begin : mon0
        logic [7:0] acc;
        int nb;
        acc = 8'h00;
        nb  = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                acc = 8'h00;
                nb  = 0;
            end else begin
                if (bus0.write_out === 1'b1) begin
                    acc = {acc[6:0], bus0.data_out};
                    nb++;
                    wr0++;
                end
                if (bus0.done_out === 1'b1) begin
                    if (q0.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb0_unexpected: actual=%0h required=none", acc);
                    end else begin
                        check("sb0_byte", acc, q0.pop_front());
                    end
                    check("sb0_bits", nb, 8);
                    nb = 0;
                end
            end
        end
    end

    // Scoreboard monitor for the gapped instance.
    initial begin : mon2
        logic [7:0] acc;
        int nb;
        acc = 8'h00;
        nb  = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                acc = 8'h00;
                nb  = 0;
            end else begin
                if (bus2.write_out === 1'b1) begin
                    acc = {acc[6:0], bus2.data_out};
                    nb++;
                end
                if (bus2.done_out === 1'b1) begin
                    if (q2.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb2_unexpected: actual=%0h required=none", acc);
                    end else begin
                        check("sb2_byte", acc, q2.pop_front());
                    end
                    check("sb2_bits", nb, 8);
                    nb = 0;
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        logic [7:0] pat;
        logic       ew;
        int         w;

        reset              = 1'b0;
        bus0.byte_in       = 8'h00;
        bus0.byte_valid_in = 1'b1;
        bus0.status_in     = 1'b1;
        bus2.byte_in       = 8'h00;
        bus2.byte_valid_in = 1'b1;
        bus2.status_in     = 1'b1;

        // Reset held with valid high: outputs stay at reset values.
        repeat (3) begin
            tick();
            check("rst_write0", bus0.write_out, 1'b0);
            check("rst_write2", bus2.write_out, 1'b0);
        end
        check("rst_ready", bus0.byte_ready_out, 1'b1);
        check("rst_data",  bus0.data_out,       1'b0);
        check("rst_done",  bus0.done_out,       1'b0);
        check("rst_busy",  bus0.busy_out,       1'b0);
        check("rst_ready2", bus2.byte_ready_out, 1'b1);
        bus0.byte_valid_in = 1'b0;
        bus2.byte_valid_in = 1'b0;
        reset = 1'b1;
        tick();
        check("idle_ready", bus0.byte_ready_out, 1'b1);

        // 0xA5, status high, no gap.
        pat = 8'hA5;
        bus0.byte_in       = pat;
        bus0.byte_valid_in = 1'b1;
        q0.push_back(pat);
        tick();
        bus0.byte_valid_in = 1'b0;
        check("a5_ready_low", bus0.byte_ready_out, 1'b0);
        check("a5_busy",      bus0.busy_out,       1'b1);
        check("a5_wait_wr",   bus0.write_out,      1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("a5_write", bus0.write_out, 1'b1);
            check("a5_bit",   bus0.data_out,  pat[7-k]);
        end
        tick();
        check("a5_done",   bus0.done_out,       1'b1);
        check("a5_ready",  bus0.byte_ready_out, 1'b1);
        check("a5_wr_end", bus0.write_out,      1'b0);
        check("a5_idle",   bus0.busy_out,       1'b0);
        tick();
        check("a5_done_pulse", bus0.done_out, 1'b0);

        // 0x3C with a 20-cycle deserializer stall.
        bus0.status_in     = 1'b0;
        bus0.byte_in       = 8'h3C;
        bus0.byte_valid_in = 1'b1;
        q0.push_back(8'h3C);
        tick();
        bus0.byte_valid_in = 1'b0;
        w = wr0;
        repeat (20) begin
            tick();
            check("stall_write", bus0.write_out, 1'b0);
        end
        check("stall_count", wr0, w);
        check("stall_busy",  bus0.busy_out, 1'b1);
        bus0.status_in = 1'b1;
        tick();
        check("stall_start", bus0.write_out, 1'b1);
        check("stall_bit0",  bus0.data_out,  1'b0);
        bus0.status_in = 1'b0;
        for (int i = 0; i < 12 && bus0.done_out !== 1'b1; i++) tick();
        check("stall_done", bus0.done_out, 1'b1);
        bus0.status_in = 1'b1;
        tick();

        // 0xFF through the BIT_GAP=2 instance: frame is 8+1+7*2 = 23 edges.
        bus2.byte_in       = 8'hFF;
        bus2.byte_valid_in = 1'b1;
        q2.push_back(8'hFF);
        tick();
        bus2.byte_valid_in = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            tick();
            ew = (c <= 22) && (((c - 1) % 3) == 0);
            check("gap_write", bus2.write_out, ew);
            if (ew) check("gap_bit", bus2.data_out, 1'b1);
            check("gap_ready", bus2.byte_ready_out, (c == 23));
            check("gap_done",  bus2.done_out,       (c == 23));
        end
        tick();

        // Back-to-back 0x01 then 0x80 with valid held high.
        bus0.byte_in       = 8'h01;
        bus0.byte_valid_in = 1'b1;
        q0.push_back(8'h01);
        tick();
        bus0.byte_in = 8'h80;
        q0.push_back(8'h80);
        for (int i = 0; i < 12 && bus0.done_out !== 1'b1; i++) tick();
        check("b2b_done1", bus0.done_out, 1'b1);
        tick();
        bus0.byte_valid_in = 1'b0;
        check("b2b_gap_wr", bus0.write_out,      1'b0);
        check("b2b_busy",   bus0.byte_ready_out, 1'b0);
        tick();
        check("b2b_start", bus0.write_out, 1'b1);
        check("b2b_bit0",  bus0.data_out,  1'b1);
        for (int i = 0; i < 12 && bus0.done_out !== 1'b1; i++) tick();
        check("b2b_done2", bus0.done_out, 1'b1);
        tick();

        // 0xF0 aborted by reset after its 4th bit, then 0x0F intact.
        bus0.byte_in       = 8'hF0;
        bus0.byte_valid_in = 1'b1;
        q0.push_back(8'hF0);
        tick();
        bus0.byte_valid_in = 1'b0;
        repeat (4) begin
            tick();
            check("abort_bit", bus0.write_out, 1'b1);
        end
        reset = 1'b0;
        #1;
        check("abort_write", bus0.write_out,      1'b0);
        check("abort_busy",  bus0.busy_out,       1'b0);
        check("abort_ready", bus0.byte_ready_out, 1'b1);
        q0.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_ready", bus0.byte_ready_out, 1'b1);
        check("post_rst_write", bus0.write_out,      1'b0);
        bus0.byte_in       = 8'h0F;
        bus0.byte_valid_in = 1'b1;
        q0.push_back(8'h0F);
        tick();
        bus0.byte_valid_in = 1'b0;
        for (int i = 0; i < 12 && bus0.done_out !== 1'b1; i++) tick();
        check("post_rst_done", bus0.done_out, 1'b1);
        tick();

        check("q0_drained", q0.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
